// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state type for the ALU datapath blocks.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_SAL  = 4'b1000;
  localparam logic [3:0] OP_SAR  = 4'b1001;
  localparam logic [3:0] OP_LAST = OP_SAR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_flags.sv
// Combinational status flags for an ALU result and the opcode that produced it.
module alu_flags
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] y,
  input  logic [3:0]   op,
  output logic         zero,
  output logic         neg,
  output logic         err
);

  assign zero = (y == '0);
  assign neg  = y[N-1];
  // Opcodes above the last defined one still reach the ALU; they are only flagged.
  assign err  = (op > OP_LAST);

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer driving an external combinational ALU.
//
// state | meaning
// IDLE  | ready for a request; on accept, operands and opcode go to the ALU
// DRIVE | ALU inputs stable for one cycle; result captured at the closing edge
// RESP  | response held until the consumer takes it
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [N-1:0]     req_a,
  input  logic [N-1:0]     req_b,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [N-1:0]     alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_y,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             rsp_err,
  output logic [CNT_W-1:0] ops_done
);

  seq_state_t state;
  logic       flag_zero;
  logic       flag_neg;
  logic       flag_err;

  alu_flags #(.N(N)) u_flags (
    .y    (alu_y),
    .op   (alu_ctrl),
    .zero (flag_zero),
    .neg  (flag_neg),
    .err  (flag_err)
  );

  // ALU operands and the response fields are never cleared on completion; they
  // hold until the next accept or capture respectively.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= '0;
      rsp_y     <= '0;
      rsp_zero  <= 1'b0;
      rsp_neg   <= 1'b0;
      rsp_err   <= 1'b0;
      ops_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a     <= req_a;
            alu_b     <= req_b;
            alu_ctrl  <= req_op;
            req_ready <= 1'b0;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          rsp_y     <= alu_y;
          rsp_zero  <= flag_zero;
          rsp_neg   <= flag_neg;
          rsp_err   <= flag_err;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            ops_done  <= ops_done + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised and directed bench for alu_sequencer with a transaction-level reference model.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [N-1:0]     req_a;
  logic [N-1:0]     req_b;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [3:0]       alu_ctrl;
  logic [N-1:0]     alu_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [N-1:0]     rsp_y;
  logic             rsp_zero;
  logic             rsp_neg;
  logic             rsp_err;
  logic [CNT_W-1:0] ops_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_y     (alu_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_zero  (rsp_zero),
    .rsp_neg   (rsp_neg),
    .rsp_err   (rsp_err),
    .ops_done  (ops_done)
  );

  // Shift ops move A by one place; B is unused for NOT and shifts; undefined ops add.
  function automatic logic [N-1:0] alu_ref(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    logic [N-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_XOR:  r = a ^ b;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SHL:  r = a << 1;
      OP_SHR:  r = a >> 1;
      OP_SAL:  r = a <<< 1;
      OP_SAR:  r = $signed(a) >>> 1;
      default: r = a + b;
    endcase
    return r;
  endfunction

  // The external ALU attached to the sequencer.
  always_comb alu_y = alu_ref(alu_ctrl, alu_a, alu_b);

  // Model: at most one outstanding transaction, aged in cycles since accept.
  bit           have_txn;
  int           age;
  logic [3:0]   t_op;
  logic [N-1:0] t_a, t_b;
  logic [N-1:0] last_y;
  bit           last_z, last_n, last_e;
  logic [CNT_W-1:0] m_cnt;
  int           completed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    have_txn = 0; age = 0;
    t_op = '0; t_a = '0; t_b = '0;
    last_y = '0; last_z = 0; last_n = 0; last_e = 0;
    m_cnt = '0;
  endtask

  task automatic check_all();
    chk("req_ready", req_ready, !have_txn);
    chk("rsp_valid", rsp_valid, have_txn && age >= 1);
    chk("rsp_y", rsp_y, last_y);
    chk("flags", {rsp_zero, rsp_neg, rsp_err}, {last_z, last_n, last_e});
    chk("alu_in", {alu_a, alu_b, alu_ctrl}, {t_a, t_b, t_op});
    chk("ops_done", ops_done, m_cnt);
  endtask

  // Predict the effect of the coming rising edge, let it happen, check at the falling edge.
  task automatic cycle();
    if (have_txn) begin
      if (age == 0) begin
        last_y = alu_ref(t_op, t_a, t_b);
        last_z = (last_y == '0);
        last_n = last_y[N-1];
        last_e = (t_op > 4'd9);
        age = 1;
      end else if (rsp_ready) begin
        have_txn = 0;
        m_cnt++;
        completed++;
      end
    end else if (req_valid) begin
      have_txn = 1; age = 0;
      t_op = req_op; t_a = req_a; t_b = req_b;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Leaves the response pending with rsp_ready low; checks the two-edge latency.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid = 1; req_op = op; req_a = a; req_b = b; rsp_ready = 0;
    cycle();
    chk("lat_accept_edge", rsp_valid, 1'b0);
    req_valid = 0;
    cycle();
    chk("lat_second_edge", rsp_valid, 1'b1);
  endtask

  task automatic drain();
    rsp_ready = 1;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_outputs", {rsp_valid, rsp_y, rsp_zero, rsp_neg, rsp_err, alu_a, alu_b, alu_ctrl},
        '0);
    chk("rst_ops_done", ops_done, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    #1;
    check_all();
  endtask

  initial begin
    logic [N-1:0] held_y;
    rst = 1; req_valid = 0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1;
    completed = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // AND
    issue(OP_AND, 4'b1100, 4'b1010);
    chk("and_y", rsp_y, 4'b1000);
    chk("and_flags", {rsp_zero, rsp_neg, rsp_err}, 3'b010);
    drain();
    chk("and_ops_done", ops_done, 8'd1);

    // ADD wrapping to zero
    issue(OP_ADD, 4'b0111, 4'b1001);
    chk("add_y", rsp_y, 4'b0000);
    chk("add_flags", {rsp_zero, rsp_neg, rsp_err}, 3'b100);
    drain();

    // Illegal opcode forwarded, defaults to add
    issue(4'b1111, 4'b0011, 4'b0010);
    chk("illegal_y", rsp_y, 4'b0101);
    chk("illegal_err", rsp_err, 1'b1);
    chk("illegal_ctrl", alu_ctrl, 4'b1111);
    drain();

    // Backpressure with a second request waiting
    issue(OP_XOR, 4'b0110, 4'b0011);
    held_y = rsp_y;
    chk("bp_y", held_y, 4'b0101);
    req_valid = 1; req_op = OP_OR; req_a = 4'b1001; req_b = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_y", rsp_y, held_y);
      chk("bp_hold_ready", req_ready, 1'b0);
    end
    chk("bp_count_before", ops_done, 8'd3);
    rsp_ready = 1;
    cycle();
    chk("bp_count_after", ops_done, 8'd4);
    chk("bp_ready_after", req_ready, 1'b1);
    cycle();
    chk("bp_second_accept", {req_ready, alu_a}, {1'b0, 4'b1001});
    req_valid = 0;
    cycle();
    chk("bp_second_y", rsp_y, 4'b1011);
    cycle();
    chk("bp_count_final", ops_done, 8'd5);

    // Reset during DRIVE
    req_valid = 1; req_op = OP_ADD; req_a = 4'b0001; req_b = 4'b0001;
    cycle();
    req_valid = 0;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    issue(OP_SUB, 4'b0010, 4'b0011);
    chk("post_rst_y", rsp_y, 4'b1111);
    drain();
    chk("post_rst_count", ops_done, 8'd1);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_op    = 4'($urandom);
      req_a     = N'($urandom);
      req_b     = N'($urandom);
      cycle();
    end
    req_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 3; i++) cycle();

    // 256 back-to-back SUB ops wrap the counter
    do_reset();
    completed = 0;
    req_valid = 1; req_op = OP_SUB; rsp_ready = 1;
    for (int i = 0; i < 1000 && completed < 256; i++) begin
      req_a = N'($urandom);
      req_b = N'($urandom);
      cycle();
    end
    req_valid = 0;
    chk("wrap_completed", completed, 256);
    chk("wrap_ops_done", ops_done, 8'h00);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator side of the ALU operand/opcode interface: accepts operation requests over a valid/ready handshake and drives A, B and the 4-bit ALU control code to an external combinational ALU instance.
- Captures the ALU result one cycle later, derives zero, negative and illegal-op flags, and presents the result over a valid/ready response handshake.
- Sits between a request source (test controller, FPGA switch/button front-end) and the ALU.

Parameters:
- N, 4, operand and result width; must match the attached ALU.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  4  ALU control code.
- req_a  in  N  operand A.
- req_b  in  N  operand B.
- alu_a  out  N  registered operand A to the ALU.
- alu_b  out  N  registered operand B to the ALU.
- alu_ctrl  out  4  registered control code to the ALU.
- alu_y  in  N  ALU result (combinational from alu_a/alu_b/alu_ctrl).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_y  out  N  captured result.
- rsp_zero  out  1  rsp_y == 0.
- rsp_neg  out  1  rsp_y[N-1].
- rsp_err  out  1  captured opcode was illegal (> 4'b1001).
- ops_done  out  CNT_W  completed-response counter.

Behaviour:
- Reset (async, rst=1): state IDLE; alu_a, alu_b, alu_ctrl, rsp_y, rsp_zero, rsp_neg, rsp_err, rsp_valid = 0; ops_done = 0; req_ready = 1 once rst deasserts.
- FSM states:
  - IDLE: req_ready=1, rsp_valid=0. On req_valid at a rising edge, register req_a/req_b/req_op into alu_a/alu_b/alu_ctrl and go to DRIVE.
  - DRIVE: one cycle; req_ready=0. ALU inputs are stable for the full cycle. At the next edge, capture alu_y into rsp_y, compute the flags, set rsp_valid=1 and go to RESP.
  - RESP: rsp_valid=1, req_ready=0. On rsp_ready at an edge, rsp_valid goes to 0, ops_done increments and the state returns to IDLE.
- Latency: rsp_valid rises 2 edges after the request-accept edge. Max throughput is one op per 3 cycles with rsp_ready held high.
- Flags are computed from alu_y at the capture edge:
  - rsp_zero = (alu_y == 0).
  - rsp_neg = alu_y[N-1].
  - rsp_err = (alu_ctrl > 4'b1001).
- Illegal opcodes (4'b1010..4'b1111) are not blocked. They are forwarded to the ALU unchanged (ALU default is addition) and rsp_y holds whatever the ALU returned, with rsp_err=1.
- Hold rules:
  - alu_a, alu_b and alu_ctrl hold their last values after completion; they are not cleared.
  - rsp_y and all flags stay stable from capture until the next capture, including under backpressure and after the handshake.
- Backpressure: with rsp_ready=0 in RESP, stay in RESP indefinitely. req_valid is ignored and no request is accepted.
- ops_done wraps from 2^CNT_W-1 to 0 with no saturation and no flag.
- Reset mid-operation (DRIVE or RESP): everything returns to reset values immediately. The in-flight op is discarded and never counted or reported.
- Simultaneous events: in IDLE, req_valid and rsp_ready together cause only the request accept; rsp_ready is ignored there.
- No combinational path from req_* or rsp_ready to any output except through the state register.

Decomposition:
- Package alu_pkg holds:
  - Opcode constants: OP_AND=4'b0000, OP_OR=0001, OP_NOT=0010, OP_XOR=0011, OP_ADD=0100, OP_SUB=0101, OP_SHL=0110, OP_SHR=0111, OP_SAL=1000, OP_SAR=1001, OP_LAST=OP_SAR.
  - State typedef seq_state_t {IDLE, DRIVE, RESP}.
- Sub-module alu_flags (combinational): inputs y and op; outputs zero, neg and err. It is shared with later datapath blocks.
- The ALU itself is instantiated outside this block, e.g. in the bench or top level.

Test Plan (N=4, real ALU attached, rsp_ready=1 unless stated):
- AND: op=0000, A=1100, B=1010 -> rsp_y=1000, rsp_neg=1, rsp_zero=0, rsp_err=0. rsp_valid rises exactly 2 edges after accept; ops_done=1.
- ADD wrap to zero: op=0100, A=0111, B=1001 -> rsp_y=0000, rsp_zero=1, rsp_neg=0.
- Illegal op: op=1111, A=0011, B=0010 -> rsp_err=1, rsp_y=0101.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid while a second req_valid is held high:
  - rsp_valid stays 1, rsp_y stays stable, req_ready stays 0.
  - After rsp_ready=1 the second request is accepted 1 cycle later; ops_done increments by exactly 1 per handshake.
- Reset mid-op: assert rst during DRIVE -> all outputs 0 immediately, ops_done=0, no rsp_valid pulse. The next request after deassertion completes normally.
- Counter wrap (CNT_W=8): 256 back-to-back SUB ops -> ops_done returns to 0x00; each response is checked against a reference model.
